layer_mem_arbiter: RTL and testbench
====================================

# layer_mem_arbiter

Shares the single layer-memory port (csel-selected banks L0 conv 001/010, L1 pool 011/100, L2 flatten 101) among independent engines: conv writer, pool reader, pool/flatten writer. Each requester presents one read or write per grant. The arbiter picks one per cycle by round-robin with optional burst lock, drives registered memory strobes, and returns read data with a fixed latency. It sits between the split conv/pool engines and the testbench layer memory.

## Interface
- NREQ, 3, number of requesters (index 0 = highest initial priority)
- AW, 12, memory address width
- DW, 20, memory data width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  NREQ  access request per requester, held until gnt
- we  in  NREQ  1 = write, 0 = read, valid with req
- lock  in  NREQ  keep grant for next access while owner's req stays high
- sel  in  3*NREQ  bank select per requester (slice i = [3i+2:3i])
- addr  in  AW*NREQ  address per requester
- wdata  in  DW*NREQ  write data per requester
- gnt  out  NREQ  one-hot, combinational, accepted-this-cycle pulse
- rvalid  out  NREQ  one-hot, read data valid for that requester
- rdata  out  DW  read data, valid when any rvalid
- err  out  1  one-cycle pulse, accepted request had illegal sel
- cwr  out  1  memory write strobe
- crd  out  1  memory read strobe
- csel  out  3  bank select
- caddr_wr  out  AW  write address
- cdata_wr  out  DW  write data
- caddr_rd  out  AW  read address
- cdata_rd  in  DW  read data, valid the cycle after crd

## Operation
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, cwr 0, crd 0, csel 000, caddr_wr 0, cdata_wr 0, caddr_rd 0; pointer = 0, owner none.
- State: IDLE (no owner) / LOCKED (owner k). At most one access accepted per cycle.
- IDLE: if any req, grant the first requester at or after pointer (circular). pointer <= winner+1 mod NREQ. If winner's lock=1, go LOCKED(winner).
- LOCKED(k): if req[k]=1, grant k only (others wait, no gnt). If req[k]=1 and lock[k]=0, grant k and return to IDLE. If req[k]=0, no lock retained: arbitrate as IDLE in the same cycle.
- Legal sel: 001..101. Illegal sel (000, 110, 111): request granted (gnt pulses, requester released), no strobe, err pulses with the strobe-cycle timing; no rvalid for a read.
- Write accept: next cycle cwr=1, csel=sel, caddr_wr=addr, cdata_wr=wdata; crd=0.
- Read accept: next cycle crd=1, csel=sel, caddr_rd=addr; cwr=0.
- Strobes are single-cycle; with no accept, cwr=crd=0, csel=000, addresses/wdata hold last value.
- Read return: rdata registered from cdata_rd at end of strobe cycle; rvalid[k] pulses one cycle after strobe. Back-to-back reads each return in order, one per cycle.
- gnt depends on req/lock/pointer/state only, never on we/sel/addr.

## Timing
- Cycle T: req sampled, gnt high combinationally. T+1: strobe on memory port. T+2: rvalid/rdata for reads.
- Throughput: one access per cycle, sustained; a locked 4-read burst completes in 4 consecutive accept cycles, data T+2..T+5.
- Requester may change addr/we/sel in the cycle after gnt; arbiter has registered the accepted fields.
- Reset asserted mid-burst: all outputs immediately to reset values, pending read returns discarded (no rvalid after reset), lock released, pointer = 0.

## Test plan
- Single write: req[0], we=1, sel=001, addr=0x005, wdata=0x00123 at T -> gnt[0] at T; T+1 cwr=1 csel=001 caddr_wr=0x005 cdata_wr=0x00123; T+2 cwr=0.
- Read latency: req[1] read sel=001 addr=0x041, memory returns 0x0ABCD -> T+1 crd=1 caddr_rd=0x041; T+2 rvalid[1]=1 rdata=0x0ABCD.
- Round-robin: all three req held continuously, no lock, from reset -> gnt order 0,1,2,0,1,2 on consecutive cycles.
- Lock burst: req[1] with lock for 3 accesses then lock=0 on 4th, req[0],[2] also high -> gnt[1] four consecutive cycles, then gnt[2], then gnt[0].
- Illegal sel: req[2] write sel=110 -> gnt[2] at T, err=1 at T+1, cwr=0, csel=000.
- Reset mid-burst: reset after 2 of 4 locked reads -> all outputs 0 during reset, no rvalid afterward; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter with burst lock that shares one layer-memory port among
// the conv/pool/flatten engines; strobes are registered, reads return two cycles after grant.
module layer_mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ-1:0]      lock,
    input  logic [3*NREQ-1:0]    sel,
    input  logic [AW*NREQ-1:0]   addr,
    input  logic [DW*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic                 cwr,
    output logic                 crd,
    output logic [2:0]           csel,
    output logic [AW-1:0]        caddr_wr,
    output logic [DW-1:0]        cdata_wr,
    output logic [AW-1:0]        caddr_rd,
    input  logic [DW-1:0]        cdata_rd
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   ptr_next;
    logic            found;
    int              idx;
    logic [NREQ-1:0] one_hot;
    logic [2:0]      win_sel;
    logic            sel_legal;
    logic [NREQ-1:0] rd_owner;

    // A locked owner that drops req gives up the lock and the cycle is arbitrated normally.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state == ST_LOCKED && req[owner]) begin
            found = 1'b1;
            win   = owner;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        one_hot      = '0;
        one_hot[win] = 1'b1;
        gnt          = (found && !reset) ? one_hot : '0;
        ptr_next     = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        win_sel      = sel[int'(win)*3 +: 3];
        sel_legal    = (win_sel >= 3'd1) && (win_sel <= 3'd5);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            rd_owner <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= 3'b000;
            caddr_wr <= '0;
            cdata_wr <= '0;
            caddr_rd <= '0;
        end else begin
            cwr    <= 1'b0;
            crd    <= 1'b0;
            csel   <= 3'b000;
            err    <= 1'b0;
            rvalid <= crd ? rd_owner : '0;
            if (crd) rdata <= cdata_rd;
            if (found) begin
                ptr <= ptr_next;
                if (lock[win]) begin
                    state <= ST_LOCKED;
                    owner <= win;
                end else begin
                    state <= ST_IDLE;
                end
                // Illegal bank: the requester is released but the memory port stays quiet.
                if (!sel_legal) begin
                    err <= 1'b1;
                end else if (we[win]) begin
                    cwr      <= 1'b1;
                    csel     <= win_sel;
                    caddr_wr <= addr[int'(win)*AW +: AW];
                    cdata_wr <= wdata[int'(win)*DW +: DW];
                end else begin
                    crd      <= 1'b1;
                    csel     <= win_sel;
                    caddr_rd <= addr[int'(win)*AW +: AW];
                    rd_owner <= one_hot;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: grant order, strobe timing, read return,
// burst lock, illegal bank handling and reset mid-burst.
module tb_layer_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ-1:0]      lock;
    logic [3*NREQ-1:0]    sel;
    logic [AW*NREQ-1:0]   addr;
    logic [DW*NREQ-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 err;
    logic                 cwr;
    logic                 crd;
    logic [2:0]           csel;
    logic [AW-1:0]        caddr_wr;
    logic [DW-1:0]        cdata_wr;
    logic [AW-1:0]        caddr_rd;
    logic [DW-1:0]        cdata_rd;

    int n_checks = 0;
    int n_fail   = 0;

    layer_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .sel(sel),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .err(err), .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Layer memory model: one known word, otherwise data derived from the address.
    always_comb begin
        if (caddr_rd == 12'h041) cdata_rd = 20'h0ABCD;
        else                     cdata_rd = {8'hC0, caddr_rd};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req   = '0;
        we    = '0;
        lock  = '0;
        sel   = '0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic set_port(input int i, input logic w, input logic [2:0] s,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        we[i]           = w;
        sel[3*i +: 3]   = s;
        addr[AW*i +: AW] = a;
        wdata[DW*i +: DW] = d;
        lock[i]         = l;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        req   = 3'b111;
        #12;
        // Reset state, with requests pending
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cwr", 32'(cwr), 32'h0);
        check("rst_crd", 32'(crd), 32'h0);
        check("rst_csel", 32'(csel), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();

        // Single write from requester 0
        req = 3'b001;
        set_port(0, 1'b1, 3'b001, 12'h005, 20'h00123, 1'b0);
        #1;
        check("wr_gnt", 32'(gnt), 32'h1);
        tick();
        idle_inputs();
        check("wr_cwr", 32'(cwr), 32'h1);
        check("wr_crd", 32'(crd), 32'h0);
        check("wr_csel", 32'(csel), 32'h1);
        check("wr_caddr", 32'(caddr_wr), 32'h005);
        check("wr_cdata", 32'(cdata_wr), 32'h00123);
        tick();
        check("wr_cwr_off", 32'(cwr), 32'h0);
        check("wr_csel_off", 32'(csel), 32'h0);
        check("wr_caddr_hold", 32'(caddr_wr), 32'h005);

        // Read latency from requester 1
        req = 3'b010;
        set_port(1, 1'b0, 3'b001, 12'h041, 20'h0, 1'b0);
        #1;
        check("rd_gnt", 32'(gnt), 32'h2);
        tick();
        idle_inputs();
        check("rd_crd", 32'(crd), 32'h1);
        check("rd_cwr", 32'(cwr), 32'h0);
        check("rd_caddr", 32'(caddr_rd), 32'h041);
        check("rd_rvalid_early", 32'(rvalid), 32'h0);
        tick();
        check("rd_rvalid", 32'(rvalid), 32'h2);
        check("rd_rdata", 32'(rdata), 32'h0ABCD);
        check("rd_crd_off", 32'(crd), 32'h0);
        tick();
        check("rd_rvalid_off", 32'(rvalid), 32'h0);

        // Round-robin from reset with back-to-back reads returning in order
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                req = 3'b111;
                for (int k = 0; k < NREQ; k++)
                    set_port(k, 1'b0, 3'b011, 12'(12'h100 * (k + 1)), 20'h0, 1'b0);
            end else begin
                idle_inputs();
            end
            #1;
            if (c < 6) check($sformatf("rr_gnt%0d", c), 32'(gnt), 32'(1 << (c % 3)));
            if (c >= 2) begin
                check($sformatf("rr_rvalid%0d", c), 32'(rvalid), 32'(1 << ((c - 2) % 3)));
                check($sformatf("rr_rdata%0d", c), 32'(rdata),
                      32'({8'hC0, 12'(12'h100 * (((c - 2) % 3) + 1))}));
            end
            tick();
        end
        idle_inputs();
        tick();

        // Lock burst: requester 1 holds the port for four writes while 0 and 2 wait
        req = 3'b010;
        set_port(1, 1'b1, 3'b010, 12'h020, 20'h11111, 1'b1);
        #1;
        check("lk_gnt0", 32'(gnt), 32'h2);
        tick();
        req = 3'b111;
        set_port(0, 1'b1, 3'b001, 12'h030, 20'h22222, 1'b0);
        set_port(2, 1'b1, 3'b101, 12'h040, 20'h33333, 1'b0);
        for (int c = 1; c < 4; c++) begin
            lock[1] = (c < 3);
            #1;
            check($sformatf("lk_gnt%0d", c), 32'(gnt), 32'h2);
            tick();
        end
        req = 3'b101;
        #1;
        check("lk_after2", 32'(gnt), 32'h4);
        check("lk_strobe_sel", 32'(csel), 32'h2);
        tick();
        req = 3'b001;
        #1;
        check("lk_after0", 32'(gnt), 32'h1);
        check("lk_strobe_sel2", 32'(csel), 32'h5);
        tick();
        idle_inputs();
        tick();

        // Locked owner drops req: lock released, another requester served the same cycle
        req = 3'b010;
        set_port(1, 1'b1, 3'b001, 12'h050, 20'h44444, 1'b1);
        #1;
        check("drop_gnt1", 32'(gnt), 32'h2);
        tick();
        idle_inputs();
        req = 3'b001;
        set_port(0, 1'b1, 3'b001, 12'h060, 20'h55555, 1'b0);
        #1;
        check("drop_gnt0", 32'(gnt), 32'h1);
        tick();
        idle_inputs();
        tick();

        // Illegal bank select on a write and on a read
        req = 3'b100;
        set_port(2, 1'b1, 3'b110, 12'h070, 20'h66666, 1'b0);
        #1;
        check("ill_gnt", 32'(gnt), 32'h4);
        tick();
        idle_inputs();
        check("ill_err", 32'(err), 32'h1);
        check("ill_cwr", 32'(cwr), 32'h0);
        check("ill_csel", 32'(csel), 32'h0);
        req = 3'b001;
        set_port(0, 1'b0, 3'b000, 12'h080, 20'h0, 1'b0);
        #1;
        check("ill_rd_gnt", 32'(gnt), 32'h1);
        tick();
        idle_inputs();
        check("ill_rd_err", 32'(err), 32'h1);
        check("ill_rd_crd", 32'(crd), 32'h0);
        tick();
        check("ill_rd_rvalid", 32'(rvalid), 32'h0);
        check("ill_err_off", 32'(err), 32'h0);

        // Reset after two of four locked reads
        req = 3'b010;
        set_port(1, 1'b0, 3'b100, 12'h010, 20'h0, 1'b1);
        #1;
        check("mb_gnt_a", 32'(gnt), 32'h2);
        tick();
        set_port(1, 1'b0, 3'b100, 12'h011, 20'h0, 1'b1);
        #1;
        check("mb_gnt_b", 32'(gnt), 32'h2);
        tick();
        check("mb_crd", 32'(crd), 32'h1);
        check("mb_rvalid", 32'(rvalid), 32'h2);
        reset = 1'b1;
        #1;
        check("mb_rst_gnt", 32'(gnt), 32'h0);
        check("mb_rst_crd", 32'(crd), 32'h0);
        check("mb_rst_rvalid", 32'(rvalid), 32'h0);
        check("mb_rst_rdata", 32'(rdata), 32'h0);
        check("mb_rst_caddr", 32'(caddr_rd), 32'h0);
        check("mb_rst_csel", 32'(csel), 32'h0);
        tick();
        req  = 3'b111;
        lock = '0;
        set_port(0, 1'b1, 3'b001, 12'h090, 20'h77777, 1'b0);
        set_port(2, 1'b1, 3'b001, 12'h0A0, 20'h88888, 1'b0);
        reset = 1'b0;
        #1;
        check("mb_post_gnt", 32'(gnt), 32'h1);
        check("mb_post_rvalid", 32'(rvalid), 32'h0);
        tick();
        idle_inputs();
        check("mb_post_rvalid2", 32'(rvalid), 32'h0);
        check("mb_post_cwr", 32'(cwr), 32'h1);
        tick();
        check("mb_post_rvalid3", 32'(rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
